// File: rtl/hs32_arb_pkg.sv
// hs32_arb_pkg: shared types and constants for the hs32 SRAM arbiter
package hs32_arb_pkg;

    localparam int DW     = 32;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {REQ_M, REQ_C0, REQ_C1} req_e;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/hs32_arb_rr2.sv
// hs32_arb_rr2: two-way round-robin picker; the pointer names the preferred requester
module hs32_arb_rr2 (
    input  logic       clk,
    input  logic       resetb,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_id,
    output logic [1:0] o_gnt,
    output logic       o_ptr
);

    logic r_ptr;

    assign o_ptr = r_ptr;

    // preferred requester wins, otherwise the other one if it is asking
    always_comb begin
        o_gnt = 2'b00;
        if (i_req[r_ptr])
            o_gnt[r_ptr] = 1'b1;
        else if (i_req[~r_ptr])
            o_gnt[~r_ptr] = 1'b1;
    end

    // after serving a requester, prefer the other one next time
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            r_ptr <= 1'b0;
        else if (i_upd)
            r_ptr <= ~i_upd_id;
    end

endmodule

// File: rtl/hs32_mem_arb.sv
// hs32_mem_arb: shares one single-port SRAM between the management port and two hs32 cores.
// Grant/conflict counters are built only when HS32_ARB_STATS_EN is defined.
module hs32_mem_arb
    import hs32_arb_pkg::*;
#(
    parameter int MEM_AW = 9
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              m_stb,
    input  logic              m_rw,
    input  logic [31:0]       m_addr,
    input  logic [DW-1:0]     m_dtw,
    output logic [DW-1:0]     m_dtr,
    output logic              m_ack,
    input  logic              c0_stb,
    input  logic              c0_rw,
    input  logic [31:0]       c0_addr,
    input  logic [DW-1:0]     c0_dtw,
    output logic [DW-1:0]     c0_dtr,
    output logic              c0_ack,
    input  logic              c1_stb,
    input  logic              c1_rw,
    input  logic [31:0]       c1_addr,
    input  logic [DW-1:0]     c1_dtw,
    output logic [DW-1:0]     c1_dtr,
    output logic              c1_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
`ifdef HS32_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_m,
    output logic [STAT_W-1:0] stat_c0,
    output logic [STAT_W-1:0] stat_c1,
    output logic [STAT_W-1:0] stat_conflict
`endif
);

    state_e              r_state, w_next;
    req_e                r_gnt, w_sel;
    logic                r_rw, r_oor;
    logic [MEM_AW-1:0]   r_addr;
    logic [DW-1:0]       r_din;
    logic [2:0][DW-1:0]  r_dtr;
    logic [2:0]          w_stb, w_ack;
    logic [1:0]          w_rr_gnt;
    logic                w_rr_ptr, w_take, w_rw, w_oor, w_unused;
    logic [31:0]         w_byte;
    logic [DW-1:0]       w_dtw, w_rdata;

    hs32_arb_rr2 u_rr (
        .clk      (clk),
        .resetb   (resetb),
        .i_req    ({c1_stb, c0_stb}),
        .i_upd    (r_state == RESP && r_gnt != REQ_M),
        .i_upd_id (r_gnt == REQ_C1),
        .o_gnt    (w_rr_gnt),
        .o_ptr    (w_rr_ptr)
    );

    assign w_stb   = {c1_stb, c0_stb, m_stb};
    assign w_take  = (r_state == IDLE) && |w_stb;
    assign w_sel   = m_stb ? REQ_M : (w_rr_gnt[0] ? REQ_C0 : REQ_C1);
    assign w_rw    = (w_sel == REQ_M) ? m_rw   : (w_sel == REQ_C0) ? c0_rw   : c1_rw;
    assign w_byte  = (w_sel == REQ_M) ? m_addr : (w_sel == REQ_C0) ? c0_addr : c1_addr;
    assign w_dtw   = (w_sel == REQ_M) ? m_dtw  : (w_sel == REQ_C0) ? c0_dtw  : c1_dtw;
    assign w_oor   = |w_byte[31:MEM_AW+2];
    assign w_rdata = (r_rw || r_oor) ? '0 : ram_dout;

    assign {c1_ack, c0_ack, m_ack} = w_ack;
    assign m_dtr    = w_ack[REQ_M]  ? w_rdata : r_dtr[REQ_M];
    assign c0_dtr   = w_ack[REQ_C0] ? w_rdata : r_dtr[REQ_C0];
    assign c1_dtr   = w_ack[REQ_C1] ? w_rdata : r_dtr[REQ_C1];
    assign ram_addr = r_addr;
    assign ram_din  = r_din;
    assign w_unused = ^{w_byte[1:0], w_rr_ptr};

    // next state plus SRAM strobes in ACCESS and the ack pulse in RESP
    always_comb begin
        w_next = r_state;
        ram_en = 1'b0;
        ram_we = 1'b0;
        w_ack  = 3'b000;
        if (w_take) begin
            w_next = ACCESS;
        end else if (r_state == ACCESS) begin
            w_next = RESP;
            ram_en = !r_oor;
            ram_we = !r_oor && r_rw;
        end else if (r_state == RESP) begin
            w_next = IDLE;
            w_ack  = 3'b001 << r_gnt;
        end
    end

    // state register and capture of the granted request
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= IDLE;
            r_gnt   <= REQ_M;
            r_rw    <= 1'b0;
            r_oor   <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_gnt  <= w_sel;
                r_rw   <= w_rw;
                r_oor  <= w_oor;
                r_addr <= w_byte[MEM_AW+1:2];
                r_din  <= w_dtw;
            end
        end
    end

    // read-data hold registers; only the requester being acked is updated
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            r_dtr <= '0;
        else if (r_state == RESP)
            r_dtr[r_gnt] <= w_rdata;
    end

`ifdef HS32_ARB_STATS_EN
    logic w_multi;

    assign w_multi = (m_stb & c0_stb) | (m_stb & c1_stb) | (c0_stb & c1_stb);

    // saturating grant counters and contended-grant counter
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            stat_m        <= '0;
            stat_c0       <= '0;
            stat_c1       <= '0;
            stat_conflict <= '0;
        end else if (w_take) begin
            if (w_sel == REQ_M)  stat_m  <= sat_inc(stat_m);
            if (w_sel == REQ_C0) stat_c0 <= sat_inc(stat_c0);
            if (w_sel == REQ_C1) stat_c1 <= sat_inc(stat_c1);
            if (w_multi) stat_conflict <= sat_inc(stat_conflict);
        end
    end
`endif

endmodule

// File: tb/tb_hs32_mem_arb.sv
// tb_hs32_mem_arb: transaction-level model check of hs32_mem_arb with a behavioural SRAM
module tb_hs32_mem_arb;

    localparam int AW = 9;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic [2:0]  stb = '0;
    logic [2:0]  rw = '0;
    logic [31:0] addr [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] dtw [3] = '{32'h0, 32'h0, 32'h0};
    logic [2:0]  ack;
    logic [31:0] m_dtr, c0_dtr, c1_dtr;
    logic [31:0] dtr [3];
    logic        ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;
`ifdef HS32_ARB_STATS_EN
    logic [15:0] st_m, st_c0, st_c1, st_cf;
`endif

    hs32_mem_arb #(.MEM_AW(AW)) dut (
        .clk(clk), .resetb(resetb),
        .m_stb(stb[0]), .m_rw(rw[0]), .m_addr(addr[0]), .m_dtw(dtw[0]), .m_dtr(m_dtr), .m_ack(ack[0]),
        .c0_stb(stb[1]), .c0_rw(rw[1]), .c0_addr(addr[1]), .c0_dtw(dtw[1]), .c0_dtr(c0_dtr), .c0_ack(ack[1]),
        .c1_stb(stb[2]), .c1_rw(rw[2]), .c1_addr(addr[2]), .c1_dtw(dtw[2]), .c1_dtr(c1_dtr), .c1_ack(ack[2]),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef HS32_ARB_STATS_EN
        , .stat_m(st_m), .stat_c0(st_c0), .stat_c1(st_c1), .stat_conflict(st_cf)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        dtr[0] = m_dtr;
        dtr[1] = c0_dtr;
        dtr[2] = c1_dtr;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural SRAM with a backdoor write port
    logic [31:0] mem [512];
    logic        mem_init = 1'b0;
    logic        bd_we = 1'b0;
    logic [8:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h1000 + 32'(i);
            mem_init <= 1'b1;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else ram_dout <= mem[ram_addr];
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: one transaction in flight, ack two cycles after grant, next grant three after
    logic [31:0] ref_mem [512];
    bit          ref_init = 1'b0;
    logic [31:0] exp_dtr [3] = '{32'h0, 32'h0, 32'h0};
    bit          pv = 1'b0, prw, poor;
    int          pg, pwho, free_at = 0, rr = 0;
    logic [8:0]  pword;
    logic [31:0] pdin;
    logic [2:0]  eack;
    bit          een, ewe;
    int          ack_who [$];
    int          ack_cyc [$];
    int          en_cnt = 0, we_cnt = 0;
    string       dnm [3] = '{"m_dtr", "c0_dtr", "c1_dtr"};

    always @(negedge clk) begin
        if (!ref_init) begin
            for (int i = 0; i < 512; i++) ref_mem[i] = 32'h1000 + 32'(i);
            ref_init = 1'b1;
        end
        if (bd_we) ref_mem[bd_addr] = bd_data;
        eack = '0;
        een = 1'b0;
        ewe = 1'b0;
        if (!resetb) begin
            pv = 1'b0;
            rr = 0;
            free_at = cyc + 1;
            for (int i = 0; i < 3; i++) exp_dtr[i] = '0;
        end else if (pv) begin
            if (cyc == pg + 1) begin
                een = !poor;
                ewe = !poor && prw;
                if (ewe) ref_mem[pword] = pdin;
            end
            if (cyc == pg + 2) begin
                eack[pwho] = 1'b1;
                exp_dtr[pwho] = (prw || poor) ? 32'h0 : ref_mem[pword];
                pv = 1'b0;
            end
        end
        chk("ack", {29'b0, ack}, {29'b0, eack});
        chk("ram_en", {31'b0, ram_en}, {31'b0, een});
        chk("ram_we", {31'b0, ram_we}, {31'b0, ewe});
        for (int i = 0; i < 3; i++) chk(dnm[i], dtr[i], exp_dtr[i]);
        if (een) chk("ram_addr", {23'b0, ram_addr}, {23'b0, pword});
        if (ewe) chk("ram_din", ram_din, pdin);
        if (!resetb) chk("ram_addr_rst", {23'b0, ram_addr}, 32'h0);
        if (|ack) begin
            ack_who.push_back(ack[0] ? 0 : ack[1] ? 1 : 2);
            ack_cyc.push_back(cyc);
        end
        en_cnt += int'(ram_en);
        we_cnt += int'(ram_we);
        if (resetb && !pv && cyc >= free_at && |stb) begin
            pwho = stb[0] ? 0 : (stb[1 + rr] ? 1 + rr : 2 - rr);
            if (pwho != 0) rr = (pwho == 1) ? 1 : 0;
            pg = cyc;
            pv = 1'b1;
            free_at = cyc + 3;
            prw = rw[pwho];
            poor = addr[pwho][31:AW+2] != 0;
            pword = addr[pwho][AW+1:2];
            pdin = dtw[pwho];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int w, input bit r, input logic [31:0] a, input logic [31:0] d);
        rw[w] = r;
        addr[w] = a;
        dtw[w] = d;
        stb[w] = 1'b1;
    endtask

    // collect n acks; autodrop releases each requester after its ack, otherwise all drop at the end
    task automatic wait_acks(input int n, input bit autodrop, input string name);
        int got = 0;
        logic [2:0] a;
        for (int k = 0; k < 60 && got < n; k++) begin
            @(negedge clk);
            a = ack;
            if (|a) got++;
            @(posedge clk);
            #1;
            if (autodrop) stb = stb & ~a;
        end
        stb = '0;
        chk(name, 32'(got), 32'(n));
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        tick();
        tick();
        resetb = 1'b1;
    endtask

    task automatic chk_order(input int s0, input int n, input int exp_who [6], input string name);
        chk({name, "_count"}, 32'(ack_who.size() - s0), 32'(n));
        for (int i = 0; i < n && s0 + i < ack_who.size(); i++) begin
            chk({name, "_who"}, 32'(ack_who[s0 + i]), 32'(exp_who[i]));
            if (i > 0) chk({name, "_gap"}, 32'(ack_cyc[s0 + i] - ack_cyc[s0 + i - 1]), 32'd3);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s0, t0, e0, w0;
        tick();
        tick();
        tick();

        // c0 and c1 both request as reset releases and keep holding
        s0 = ack_who.size();
        set_req(1, 1'b0, 32'h0000_0010, 32'h0);
        set_req(2, 1'b0, 32'h0000_0014, 32'h0);
        resetb = 1'b1;
        wait_acks(6, 1'b0, "alt_acks");
        chk_order(s0, 6, '{1, 2, 1, 2, 1, 2}, "alt");
        chk("alt_c1_dtr", c1_dtr, 32'h0000_1005);

        // management write then read of byte address 4
        w0 = we_cnt;
        t0 = cyc;
        set_req(0, 1'b1, 32'h0000_0004, 32'h0000_CAFE);
        wait_acks(1, 1'b1, "m_wr_ack");
        chk("m_wr_lat", 32'(ack_cyc[$] - t0), 32'd2);
        chk("m_wr_we_cycles", 32'(we_cnt - w0), 32'd1);
        t0 = cyc;
        set_req(0, 1'b0, 32'h0000_0004, 32'h0);
        wait_acks(1, 1'b1, "m_rd_ack");
        chk("m_rd_lat", 32'(ack_cyc[$] - t0), 32'd2);
        chk("m_rd_data", m_dtr, 32'h0000_CAFE);
        chk("m_rd_we_cycles", 32'(we_cnt - w0), 32'd1);

        // all three strobe together after a fresh reset
        do_reset();
        s0 = ack_who.size();
        set_req(0, 1'b0, 32'h0000_0004, 32'h0);
        set_req(1, 1'b1, 32'h0000_0010, 32'h0000_1234);
        set_req(2, 1'b0, 32'h0000_0014, 32'h0);
        wait_acks(3, 1'b1, "tri_acks");
        chk_order(s0, 3, '{0, 1, 2, 0, 0, 0}, "tri");
        chk("tri_m_dtr", m_dtr, 32'h0000_CAFE);
        chk("tri_c1_dtr", c1_dtr, 32'h0000_1005);
`ifdef HS32_ARB_STATS_EN
        chk("stat_m", {16'b0, st_m}, 32'd1);
        chk("stat_c0", {16'b0, st_c0}, 32'd1);
        chk("stat_c1", {16'b0, st_c1}, 32'd1);
        chk("stat_conflict", {16'b0, st_cf}, 32'd2);
`endif

        // out-of-range read by c1 and out-of-range write by c0
        e0 = en_cnt;
        t0 = cyc;
        set_req(2, 1'b0, 32'h0000_0800, 32'h0);
        wait_acks(1, 1'b1, "oor_rd_ack");
        chk("oor_rd_lat", 32'(ack_cyc[$] - t0), 32'd2);
        chk("oor_rd_dtr", c1_dtr, 32'h0);
        chk("oor_rd_en_cycles", 32'(en_cnt - e0), 32'd0);
        set_req(1, 1'b1, 32'h0000_1004, 32'h0000_DEAD);
        wait_acks(1, 1'b1, "oor_wr_ack");
        chk("oor_wr_en_cycles", 32'(en_cnt - e0), 32'd0);
        set_req(0, 1'b0, 32'h0000_0004, 32'h0);
        wait_acks(1, 1'b1, "oor_wr_check_ack");
        chk("oor_wr_dropped", m_dtr, 32'h0000_CAFE);

        // reset pulse during the ACCESS cycle of a c0 write
        s0 = ack_who.size();
        set_req(1, 1'b1, 32'h0000_0008, 32'h0000_BEEF);
        tick();
        chk("abort_en_before", {31'b0, ram_en}, 32'd1);
        resetb = 1'b0;
        stb = '0;
        #1;
        chk("abort_en_drop", {31'b0, ram_en}, 32'd0);
        tick();
        tick();
        resetb = 1'b1;
        tick();
        tick();
        chk("abort_no_ack", 32'(ack_who.size() - s0), 32'd0);
        s0 = ack_who.size();
        set_req(1, 1'b0, 32'h0000_0008, 32'h0);
        set_req(2, 1'b0, 32'h0000_000C, 32'h0);
        wait_acks(2, 1'b1, "post_rst_acks");
        chk_order(s0, 2, '{1, 2, 0, 0, 0, 0}, "post_rst");
        chk("abort_no_write", c0_dtr, 32'h0000_1002);

        // backdoor preload, then c0 holds a read of word 1 for three transactions
        bd_addr = 9'd1;
        bd_data = 32'h0000_0005;
        bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
        s0 = ack_who.size();
        set_req(1, 1'b0, 32'h0000_0004, 32'h0);
        wait_acks(3, 1'b0, "hold_acks");
        chk_order(s0, 3, '{1, 1, 1, 0, 0, 0}, "hold");
        chk("hold_dtr", c0_dtr, 32'h0000_0005);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hs32_mem_arb.md
Name: hs32_mem_arb

Overview:
Arbiter/sequencer sharing one single-port 32-bit SRAM macro between the two hs32 core memory ports (core0, core1) and the Caravel management Wishbone bridge. Sits in the user project wrapper between the core instances and the SRAM. The management port has fixed top priority so firmware can preload programs. The two cores alternate round-robin.

Parameters:
MEM_AW, 9, SRAM word-address width (512 x 32b)
DW, 32, data width; fixed at 32, kept for the package

Ports:
clk  in  1  system clock
resetb  in  1  asynchronous active-low reset
m_stb, c0_stb, c1_stb  in  1 each  request strobe; held until ack
m_rw, c0_rw, c1_rw  in  1 each  1 = write, 0 = read
m_addr, c0_addr, c1_addr  in  32 each  byte address; [1:0] ignored
m_dtw, c0_dtw, c1_dtw  in  32 each  write data
m_dtr, c0_dtr, c1_dtr  out  32 each  read data, valid with ack
m_ack, c0_ack, c1_ack  out  1 each  one-cycle completion pulse
ram_en  out  1  SRAM enable
ram_we  out  1  SRAM write enable
ram_addr  out  MEM_AW  SRAM word address
ram_din  out  32  SRAM write data
ram_dout  in  32  SRAM read data; valid the cycle after ram_en

Behaviour:
- Reset (async, resetb low): state IDLE; all acks 0; all dtr 0; ram_en/ram_we 0; ram_addr/ram_din 0; rr pointer = core0. Reset mid-transaction aborts it; no ack is issued.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Evaluate strobes each cycle.
  - Grant order: m first. Otherwise the core indicated by the rr pointer, else the other core.
  - On grant, register the grant, rw, word address (addr[MEM_AW+1:2]) and dtw, then go to ACCESS.
- ACCESS (1 cycle):
  - ram_en=1, ram_we=rw, ram_addr/ram_din from the registered values.
  - Out-of-range request (addr[31:MEM_AW+2] != 0): ram_en=0 and the range flag is latched.
- RESP (1 cycle):
  - Granted requester's ack=1. Its dtr = ram_dout for an in-range read, 0 for a write or out-of-range read.
  - Non-granted dtr holds its previous value.
  - If the granted requester was a core, rr points to the other core.
  - Next state IDLE.
- Latency: stb sampled in cycle N -> ack in N+2. Minimum issue interval 3 cycles per transaction.
- Handshake:
  - The requester must hold stb/rw/addr/dtw stable until ack. Inputs are captured at grant, so later changes do not affect the current transaction.
  - A stb still high in the cycle after ack is treated as a new request.
- Simultaneous requests:
  - m beats both cores.
  - c0 and c1 together: the rr holder wins; the other is served next, unless m intervenes.
- m starvation of the cores is permitted by design.
- Writes to out-of-range addresses are dropped silently but still acked.

Optional Feature:
Macro HS32_ARB_STATS_EN.
- Defined: adds outputs stat_m, stat_c0, stat_c1 (16b each, grant counts) and stat_conflict (16b).
  - stat_conflict counts IDLE-grant cycles where two or more strobes were high.
  - All four counters saturate at 0xFFFF and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package hs32_arb_pkg:
  - requester-id enum (REQ_M, REQ_C0, REQ_C1)
  - FSM state enum (IDLE, ACCESS, RESP)
  - DW constant
  - STAT_W=16
- One sub-module, hs32_arb_rr2: 2-way round-robin picker (req[1:0], update, grant onehot, pointer flop). Also usable by the core-fabric arbiter.

Test Plan:
- m writes 0xCAFE to 0x04, then reads 0x04 -> m_ack at N+2 each time; m_dtr=0x0000CAFE; ram_we high only in the write's ACCESS cycle.
- c0 and c1 strobe together at reset exit, both held -> c0 acked first; c1 acked 3 cycles later; then c0 again (alternation over 6 grants).
- m, c0, c1 all strobe together -> order m, c0, c1; stats (if enabled) m=1, c0=1, c1=1, conflict=2.
- c1 reads 0x00000800 with MEM_AW=9 (out of range) -> ack at N+2; dtr=0; ram_en never asserted.
- resetb pulsed low during ACCESS of a c0 write -> no c0_ack; ram_en drops immediately; after release, state IDLE and rr=core0.
- Backdoor preload 0x5 at word 1; c0 holds stb with addr 0x4 for 3 transactions -> 3 acks spaced 3 cycles apart, dtr=0x5 each.
